// File: rtl/regfile_writeback.sv
// Regfile write-side merger: ALU and load completions share one registered write port,
// with a small load buffer and a same-cycle read/write bypass on the read response.
package regfile_writeback_pkg;

    typedef struct packed {
        logic        w_en;
        logic [4:0]  w_addr;
        logic [31:0] w_data;
    } regfile_w_req_st;

    typedef struct packed {
        logic [4:0] r_addr_1;
        logic [4:0] r_addr_2;
    } regfile_r_req_st;

    typedef struct packed {
        logic [31:0] r_data_1;
        logic [31:0] r_data_2;
    } regfile_r_resp_st;

endpackage

module regfile_writeback
    import regfile_writeback_pkg::*;
#(
    parameter int LD_FIFO_DEPTH = 4
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_alu_valid,
    input  logic [4:0]       i_alu_rd,
    input  logic [31:0]      i_alu_data,
    input  logic             i_ld_valid,
    output logic             o_ld_ready,
    input  logic [4:0]       i_ld_rd,
    input  logic [31:0]      i_ld_data,
    output regfile_w_req_st  o_w_req,
    input  regfile_r_req_st  i_r_req,
    input  regfile_r_resp_st i_r_resp,
    output regfile_r_resp_st o_r_resp,
    output logic             o_idle
);

    localparam int PTR_W = $clog2(LD_FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [4:0]       buf_rd   [LD_FIFO_DEPTH];
    logic [31:0]      buf_data [LD_FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;

    logic             ld_accept;
    logic             sel_valid;
    logic             sel_ld;
    logic [4:0]       sel_rd;
    logic [31:0]      sel_data;
    logic             push;
    logic             pop;

    logic             last_en;
    logic [4:0]       last_addr;
    logic [31:0]      last_data;
    regfile_r_req_st  r_req_q;

    // Ready looks only at registered state so the load unit never sees a valid->ready loop.
    assign o_ld_ready = !i_rst && (count < CNT_W'(LD_FIFO_DEPTH));
    assign ld_accept  = i_ld_valid && o_ld_ready;

    always_comb begin
        sel_valid = 1'b0;
        sel_ld    = 1'b0;
        sel_rd    = '0;
        sel_data  = '0;
        pop       = 1'b0;
        if (i_alu_valid) begin
            sel_valid = 1'b1;
            sel_rd    = i_alu_rd;
            sel_data  = i_alu_data;
        end else if (count != '0) begin
            sel_valid = 1'b1;
            sel_rd    = buf_rd[rd_ptr];
            sel_data  = buf_data[rd_ptr];
            pop       = 1'b1;
        end else if (ld_accept) begin
            sel_valid = 1'b1;
            sel_ld    = 1'b1;
            sel_rd    = i_ld_rd;
            sel_data  = i_ld_data;
        end
        push = ld_accept && !sel_ld;
    end

    always_ff @(posedge i_clk) begin
        if (push) begin
            buf_rd[wr_ptr]   <= i_ld_rd;
            buf_data[wr_ptr] <= i_ld_data;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // x0 completions are consumed but never drive w_en; addr/data hold when idle.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_w_req <= '0;
        end else if (sel_valid) begin
            o_w_req.w_en   <= (sel_rd != 5'd0);
            o_w_req.w_addr <= sel_rd;
            o_w_req.w_data <= sel_data;
        end else begin
            o_w_req.w_en   <= 1'b0;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            last_en   <= 1'b0;
            last_addr <= '0;
            last_data <= '0;
            r_req_q   <= '0;
        end else begin
            last_en   <= o_w_req.w_en;
            last_addr <= o_w_req.w_addr;
            last_data <= o_w_req.w_data;
            r_req_q   <= i_r_req;
        end
    end

    // The regfile returns pre-write data when read and write hit the same cycle; patch it here.
    always_comb begin
        o_r_resp = i_r_resp;
        if (r_req_q.r_addr_1 == 5'd0) begin
            o_r_resp.r_data_1 = '0;
        end else if (last_en && (last_addr == r_req_q.r_addr_1)) begin
            o_r_resp.r_data_1 = last_data;
        end
        if (r_req_q.r_addr_2 == 5'd0) begin
            o_r_resp.r_data_2 = '0;
        end else if (last_en && (last_addr == r_req_q.r_addr_2)) begin
            o_r_resp.r_data_2 = last_data;
        end
    end

    assign o_idle = (count == '0) && !o_w_req.w_en;

endmodule

// File: tb/tb_regfile_writeback.sv
// Directed bench for regfile_writeback: expected writes go into a scoreboard queue,
// a negedge monitor pops and compares every emitted write.
module tb_regfile_writeback;
    import regfile_writeback_pkg::*;

    logic             clk = 1'b0;
    logic             rst;
    logic             alu_valid;
    logic [4:0]       alu_rd;
    logic [31:0]      alu_data;
    logic             ld_valid;
    logic             ld_ready;
    logic [4:0]       ld_rd;
    logic [31:0]      ld_data;
    regfile_w_req_st  w_req;
    regfile_r_req_st  r_req;
    regfile_r_resp_st r_resp_raw;
    regfile_r_resp_st r_resp;
    logic             idle;

    int tests = 0;
    int fails = 0;
    logic [36:0] exp_q[$];

    always #5 clk = ~clk;

    regfile_writeback #(.LD_FIFO_DEPTH(4)) dut (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_alu_valid(alu_valid),
        .i_alu_rd   (alu_rd),
        .i_alu_data (alu_data),
        .i_ld_valid (ld_valid),
        .o_ld_ready (ld_ready),
        .i_ld_rd    (ld_rd),
        .i_ld_data  (ld_data),
        .o_w_req    (w_req),
        .i_r_req    (r_req),
        .i_r_resp   (r_resp_raw),
        .o_r_resp   (r_resp),
        .o_idle     (idle)
    );

    always @(negedge clk) begin
        if (w_req.w_en !== 1'b0) begin
            logic [36:0] exp;
            tests++;
            if (exp_q.size() == 0) begin
                fails++;
                $display("FAIL unexpected_write: got en=%b addr=%0d data=%h, required no write",
                         w_req.w_en, w_req.w_addr, w_req.w_data);
            end else begin
                exp = exp_q.pop_front();
                if ({w_req.w_en, w_req.w_addr, w_req.w_data} !== {1'b1, exp}) begin
                    fails++;
                    $display("FAIL write_order: got en=%b addr=%0d data=%h, required addr=%0d data=%h",
                             w_req.w_en, w_req.w_addr, w_req.w_data, exp[36:32], exp[31:0]);
                end
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, required %h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    initial begin
        int nacc;
        int k;
        logic acc;
        rst        = 1'b1;
        alu_valid  = 1'b0;
        alu_rd     = '0;
        alu_data   = '0;
        ld_valid   = 1'b0;
        ld_rd      = '0;
        ld_data    = '0;
        r_req      = '0;
        r_resp_raw = '0;

        // reset state
        tick();
        chk("rst_w_en", 32'(w_req.w_en), 32'd0);
        chk("rst_w_addr", 32'(w_req.w_addr), 32'd0);
        chk("rst_w_data", w_req.w_data, 32'd0);
        chk("rst_ld_ready", 32'(ld_ready), 32'd0);
        tick();
        rst = 1'b0;
        settle();
        chk("post_rst_ld_ready", 32'(ld_ready), 32'd1);
        chk("post_rst_idle", 32'(idle), 32'd1);

        // ALU alone
        alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'hDEADBEEF;
        exp_q.push_back({5'd5, 32'hDEADBEEF});
        tick();
        alu_valid = 1'b0;
        chk("alu_c1_en", 32'(w_req.w_en), 32'd1);
        chk("alu_c1_addr", 32'(w_req.w_addr), 32'd5);
        chk("alu_c1_data", w_req.w_data, 32'hDEADBEEF);
        tick();
        chk("alu_c2_en", 32'(w_req.w_en), 32'd0);
        chk("alu_c2_idle", 32'(idle), 32'd1);

        // ALU and load collide
        alu_valid = 1'b1; alu_rd = 5'd3; alu_data = 32'h11;
        ld_valid  = 1'b1; ld_rd  = 5'd7; ld_data  = 32'h22;
        exp_q.push_back({5'd3, 32'h11});
        exp_q.push_back({5'd7, 32'h22});
        settle();
        chk("coll_c0_ready", 32'(ld_ready), 32'd1);
        tick();
        alu_valid = 1'b0; ld_valid = 1'b0;
        settle();
        chk("coll_c1_addr", 32'(w_req.w_addr), 32'd3);
        chk("coll_c1_ready", 32'(ld_ready), 32'd1);
        tick();
        chk("coll_c2_en", 32'(w_req.w_en), 32'd1);
        chk("coll_c2_addr", 32'(w_req.w_addr), 32'd7);
        chk("coll_c2_data", w_req.w_data, 32'h22);
        tick();
        chk("coll_c3_idle", 32'(idle), 32'd1);

        // backpressure: ALU busy 6 cycles, load offered every cycle
        for (int i = 0; i < 6; i++) exp_q.push_back({5'(10 + i), 32'hA000 + 32'(i)});
        for (int i = 0; i < 4; i++) exp_q.push_back({5'(20 + i), 32'hB000 + 32'(i)});
        nacc = 0;
        for (int i = 0; i < 6; i++) begin
            alu_valid = 1'b1; alu_rd = 5'(10 + i); alu_data = 32'hA000 + 32'(i);
            ld_valid  = 1'b1; ld_rd  = 5'(20 + nacc); ld_data = 32'hB000 + 32'(nacc);
            settle();
            chk("bp_ready", 32'(ld_ready), (i < 4) ? 32'd1 : 32'd0);
            acc = ld_ready;
            tick();
            if (acc) nacc++;
        end
        alu_valid = 1'b0; ld_valid = 1'b0;
        chk("bp_accepted", 32'(nacc), 32'd4);
        settle();
        chk("bp_full_ready", 32'(ld_ready), 32'd0);
        repeat (5) tick();
        chk("bp_drain_idle", 32'(idle), 32'd1);
        chk("bp_drain_ready", 32'(ld_ready), 32'd1);

        // x0 load
        ld_valid = 1'b1; ld_rd = 5'd0; ld_data = 32'hFFFF;
        r_req.r_addr_1 = 5'd0;
        settle();
        chk("x0_ready", 32'(ld_ready), 32'd1);
        tick();
        ld_valid = 1'b0;
        r_resp_raw.r_data_1 = 32'h5555_5555;
        settle();
        chk("x0_w_en", 32'(w_req.w_en), 32'd0);
        chk("x0_idle", 32'(idle), 32'd1);
        chk("x0_read_zero", r_resp.r_data_1, 32'd0);
        tick();
        r_resp_raw = '0;

        // bypass
        alu_valid = 1'b1; alu_rd = 5'd9; alu_data = 32'hCAFE;
        exp_q.push_back({5'd9, 32'hCAFE});
        tick();
        alu_valid = 1'b0;
        r_req.r_addr_1 = 5'd8; r_req.r_addr_2 = 5'd9;
        settle();
        chk("byp_w_addr", 32'(w_req.w_addr), 32'd9);
        tick();
        r_resp_raw.r_data_1 = 32'h8888;
        r_resp_raw.r_data_2 = 32'h1234;
        settle();
        chk("byp_data_2", r_resp.r_data_2, 32'hCAFE);
        chk("byp_data_1", r_resp.r_data_1, 32'h8888);
        tick();
        settle();
        chk("byp_expired", r_resp.r_data_2, 32'h1234);
        r_req = '0; r_resp_raw = '0;
        tick();

        // reset while three loads are buffered
        for (int i = 0; i < 3; i++) begin
            alu_valid = 1'b1; alu_rd = 5'(1 + i); alu_data = 32'hC000 + 32'(i);
            ld_valid  = 1'b1; ld_rd  = 5'(20 + i); ld_data = 32'hD000 + 32'(i);
            exp_q.push_back({5'(1 + i), 32'hC000 + 32'(i)});
            tick();
        end
        alu_valid = 1'b0; ld_valid = 1'b0; rst = 1'b1;
        settle();
        chk("mid_rst_ready", 32'(ld_ready), 32'd0);
        tick();
        rst = 1'b0;
        chk("mid_rst_w_en", 32'(w_req.w_en), 32'd0);
        settle();
        chk("mid_rst_idle", 32'(idle), 32'd1);
        chk("mid_rst_ready_after", 32'(ld_ready), 32'd1);
        repeat (10) tick();
        chk("mid_rst_still_idle", 32'(idle), 32'd1);

        k = 0;
        while (exp_q.size() != 0 && k < 20) begin
            tick();
            k++;
        end
        chk("scoreboard_drain", 32'(exp_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
